// File: rtl/jtag_debug_host_shifter.sv
// Host-side JTAG TAP driver: walks the 1149.1 TAP over tck/tms/tdi to scan one IR (+ optional DR) per command.
// Latency: 2*TCK_DIV*(IR_WIDTH+DR_WIDTH+11) clk from accept to rsp_valid (2*TCK_DIV*(IR_WIDTH+6) for IR-only).
// Backpressure: cmd_ready is low during init and while a scan is in flight; cmd_valid is ignored then.
module jtag_debug_host_shifter #(
    parameter int IR_WIDTH = 2,
    parameter int DR_WIDTH = 38,
    parameter int TCK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    input  logic                cmd_ir_only,
    output logic                rsp_valid,
    output logic [IR_WIDTH-1:0] rsp_ir,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic                busy,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo
);

    localparam int N_PER = IR_WIDTH + DR_WIDTH + 11;
    localparam int PW    = $clog2(N_PER + 1);
    localparam int DW    = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(TCK_DIV - 1);

    // Period indices within a command, counted from the accept edge.
    localparam logic [PW-1:0] P_IR_SH    = PW'(4);
    localparam logic [PW-1:0] P_IR_LAST  = PW'(IR_WIDTH + 3);
    localparam logic [PW-1:0] P_IR_UPD   = PW'(IR_WIDTH + 4);
    localparam logic [PW-1:0] P_IR_END   = PW'(IR_WIDTH + 5);
    localparam logic [PW-1:0] P_DR_SEL   = PW'(IR_WIDTH + 6);
    localparam logic [PW-1:0] P_DR_SH    = PW'(IR_WIDTH + 9);
    localparam logic [PW-1:0] P_DR_LAST  = PW'(IR_WIDTH + DR_WIDTH + 8);
    localparam logic [PW-1:0] P_DR_UPD   = PW'(IR_WIDTH + DR_WIDTH + 9);
    localparam logic [PW-1:0] P_DR_END   = PW'(N_PER - 1);
    localparam logic [PW-1:0] P_INIT_RTI = PW'(5);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_RUN
    } state_t;

    state_t              state;
    logic [PW-1:0]       per_cnt;
    logic [DW-1:0]       div_cnt;
    logic [IR_WIDTH-1:0] ir_sh;
    logic [DR_WIDTH-1:0] dr_sh;
    logic                ir_only_q;
    logic                in_ir_sh;
    logic                in_dr_sh;

    logic [PW-1:0]       nxt_per;
    logic [PW-1:0]       last_per;
    logic                nxt_tms;
    logic                nxt_ir_sh;
    logic                nxt_dr_sh;
    logic [IR_WIDTH-1:0] ir_shifted;
    logic [DR_WIDTH-1:0] dr_shifted;

    always_comb begin
        nxt_per   = per_cnt + PW'(1);
        nxt_ir_sh = (state == S_RUN) && (nxt_per >= P_IR_SH) && (nxt_per <= P_IR_LAST);
        nxt_dr_sh = (state == S_RUN) && (nxt_per >= P_DR_SH) && (nxt_per <= P_DR_LAST);
        if (state == S_INIT) begin
            nxt_tms = (nxt_per < P_INIT_RTI);
        end else begin
            nxt_tms = (nxt_per == PW'(1)) || (nxt_per == P_IR_LAST) || (nxt_per == P_IR_UPD) ||
                      (nxt_per == P_DR_SEL) || (nxt_per == P_DR_LAST) || (nxt_per == P_DR_UPD);
        end
        if (state == S_INIT)
            last_per = P_INIT_RTI;
        else if (ir_only_q)
            last_per = P_IR_END;
        else
            last_per = P_DR_END;
        // One register per scan both drives tdi from bit 0 and collects tdo at the top.
        ir_shifted = IR_WIDTH'({tdo, ir_sh} >> 1);
        dr_shifted = DR_WIDTH'({tdo, dr_sh} >> 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_INIT;
            per_cnt   <= '0;
            div_cnt   <= '0;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_ir    <= '0;
            rsp_dr    <= '0;
            busy      <= 1'b1;
            ir_sh     <= '0;
            dr_sh     <= '0;
            ir_only_q <= 1'b0;
            in_ir_sh  <= 1'b0;
            in_dr_sh  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state     <= S_RUN;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        ir_sh     <= cmd_ir;
                        dr_sh     <= cmd_dr;
                        ir_only_q <= cmd_ir_only;
                        per_cnt   <= '0;
                        div_cnt   <= '0;
                        tms       <= 1'b1;
                        tdi       <= 1'b0;
                        in_ir_sh  <= 1'b0;
                        in_dr_sh  <= 1'b0;
                    end
                end
                default: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + DW'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!tck) begin
                            tck <= 1'b1;
                            if (in_ir_sh) ir_sh <= ir_shifted;
                            if (in_dr_sh) dr_sh <= dr_shifted;
                        end else begin
                            tck <= 1'b0;
                            if (per_cnt == last_per) begin
                                state     <= S_IDLE;
                                per_cnt   <= '0;
                                tms       <= 1'b0;
                                tdi       <= 1'b0;
                                in_ir_sh  <= 1'b0;
                                in_dr_sh  <= 1'b0;
                                cmd_ready <= 1'b1;
                                busy      <= 1'b0;
                                if (state == S_RUN) begin
                                    rsp_valid <= 1'b1;
                                    rsp_ir    <= ir_sh;
                                    rsp_dr    <= ir_only_q ? '0 : dr_sh;
                                end
                            end else begin
                                per_cnt  <= nxt_per;
                                tms      <= nxt_tms;
                                in_ir_sh <= nxt_ir_sh;
                                in_dr_sh <= nxt_dr_sh;
                                tdi      <= nxt_ir_sh ? ir_sh[0] : (nxt_dr_sh ? dr_sh[0] : 1'b0);
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_debug_host_shifter.sv
// Directed bench: two shifters (TCK_DIV=4 and TCK_DIV=1) share one behavioural TAP target through a mux.
module tb_jtag_debug_host_shifter;

    localparam logic [37:0] DR_INIT = 38'h2A_5A5A_5A5A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_valid1 = 1'b0;
    logic [1:0]  cmd_ir = '0;
    logic [37:0] cmd_dr = '0;
    logic        cmd_ir_only = 1'b0;
    logic        sel = 1'b0;
    logic        tdo_m = 1'b0;

    logic        cmd_ready, rsp_valid, busy, tck, tms, tdi;
    logic [1:0]  rsp_ir;
    logic [37:0] rsp_dr;
    logic        cmd_ready1, rsp_valid1, busy1, tck1, tms1, tdi1;
    logic [1:0]  rsp_ir1;
    logic [37:0] rsp_dr1;

    int errors = 0;
    int checks = 0;
    int rsp_cnt0 = 0;

    jtag_debug_host_shifter u_dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .cmd_ir_only(cmd_ir_only),
        .rsp_valid(rsp_valid), .rsp_ir(rsp_ir), .rsp_dr(rsp_dr), .busy(busy),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo_m)
    );

    jtag_debug_host_shifter #(.TCK_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .cmd_ir_only(cmd_ir_only),
        .rsp_valid(rsp_valid1), .rsp_ir(rsp_ir1), .rsp_dr(rsp_dr1), .busy(busy1),
        .tck(tck1), .tms(tms1), .tdi(tdi1), .tdo(tdo_m)
    );

    wire tck_m = sel ? tck1 : tck;
    wire tms_m = sel ? tms1 : tms;
    wire tdi_m = sel ? tdi1 : tdi;

    always @(negedge clk) if (rsp_valid === 1'b1) rsp_cnt0++;

    // Target TAP: IR echoes the last updated IR; DR is a 38-bit loopback. TLR reloads both.
    typedef enum logic [3:0] {TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                              SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_t;
    tap_t        st = TLR;
    logic [1:0]  ir_reg = 2'b01, ir_sr = '0;
    logic [37:0] dr_reg = DR_INIT, dr_sr = '0;
    int          ir_caps = 0, dr_caps = 0, dr_bits = 0;
    bit          tms_q[$];

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:  return m ? TLR  : RTI;
            RTI:  return m ? SDR  : RTI;
            SDR:  return m ? SIR  : CDR;
            CDR:  return m ? E1DR : SHDR;
            SHDR: return m ? E1DR : SHDR;
            E1DR: return m ? UDR  : PDR;
            PDR:  return m ? E2DR : PDR;
            E2DR: return m ? UDR  : SHDR;
            UDR:  return m ? SDR  : RTI;
            SIR:  return m ? TLR  : CIR;
            CIR:  return m ? E1IR : SHIR;
            SHIR: return m ? E1IR : SHIR;
            E1IR: return m ? UIR  : PIR;
            PIR:  return m ? E2IR : PIR;
            E2IR: return m ? UIR  : SHIR;
            default: return m ? SDR : RTI;
        endcase
    endfunction

    always @(posedge tck_m) begin
        tms_q.push_back(tms_m);
        case (st)
            TLR:  begin ir_reg = 2'b01; dr_reg = DR_INIT; end
            CIR:  begin ir_sr = ir_reg; ir_caps++; end
            SHIR: ir_sr = {tdi_m, ir_sr[1]};
            UIR:  ir_reg = ir_sr;
            CDR:  begin dr_sr = dr_reg; dr_caps++; dr_bits = 0; end
            SHDR: begin dr_sr = {tdi_m, dr_sr[37:1]}; dr_bits++; end
            UDR:  dr_reg = dr_sr;
            default: ;
        endcase
        st = tap_next(st, tms_m);
    end

    always @(negedge tck_m)
        tdo_m = (st == SHIR) ? ir_sr[0] : ((st == SHDR) ? dr_sr[0] : 1'b0);

    task automatic run_cmd(input logic [1:0] ir, input logic [37:0] dr, input logic ir_only,
                           output int lat);
        @(negedge clk);
        cmd_ir = ir; cmd_dr = dr; cmd_ir_only = ir_only; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) begin lat = n; break; end
        end
    endtask

    // Releases reset at the current negedge and checks the INIT walk and its length.
    task automatic check_init(input string tag);
        int mark, n;
        bit ok;
        mark = tms_q.size();
        reset = 1'b0;
        n = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (cmd_ready === 1'b1) begin n = k; break; end
        end
        checks++;
        if (n != 48) begin errors++; $display("FAIL %s_init_len: cmd_ready after %0d cycles, want 48", tag, n); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s_init_busy: busy=%b want 0", tag, busy); end
        ok = (tms_q.size() - mark == 6);
        if (ok) for (int i = 0; i < 6; i++) if (tms_q[mark+i] != (i < 5)) ok = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_init_tms: %0d tck rises or wrong tms, want 6 rises tms=111110", tag, tms_q.size() - mark); end
    endtask

    task automatic test_reset;
        bit still;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({tck, tms, tdi, cmd_ready, rsp_valid, busy} !== 6'b010001) begin
            errors++; $display("FAIL reset_ctrl: tck,tms,tdi,rdy,vld,busy=%b want 010001", {tck, tms, tdi, cmd_ready, rsp_valid, busy});
        end
        checks++;
        if (rsp_ir !== 2'b00 || rsp_dr !== 38'h0) begin
            errors++; $display("FAIL reset_rsp: rsp_ir=%h rsp_dr=%h want 0", rsp_ir, rsp_dr);
        end
        check_init("reset");
        still = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tck !== 1'b0 || tms !== 1'b0) still = 0;
        end
        checks++;
        if (!still) begin errors++; $display("FAIL idle_tck: tck/tms moved while idle, want 0"); end
    endtask

    task automatic test_full_cmd;
        int lat, mark;
        bit ok;
        bit exp_q[$];
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL full_ready: cmd_ready=%b want 1", cmd_ready); end
        mark = tms_q.size();
        run_cmd(2'b10, 38'h15_1234_5678, 1'b0, lat);
        checks++;
        if (lat != 408) begin errors++; $display("FAIL full_latency: %0d want 408", lat); end
        checks++;
        if (rsp_ir !== 2'b01) begin errors++; $display("FAIL full_rsp_ir: %b want 01", rsp_ir); end
        checks++;
        if (rsp_dr !== DR_INIT) begin errors++; $display("FAIL full_rsp_dr: %h want %h", rsp_dr, DR_INIT); end
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL full_done_flags: rdy=%b busy=%b want 1 0", cmd_ready, busy);
        end
        checks++;
        if (ir_reg !== 2'b10) begin errors++; $display("FAIL full_target_ir: %b want 10", ir_reg); end
        checks++;
        if (dr_reg !== 38'h15_1234_5678) begin errors++; $display("FAIL full_target_dr: %h want 1512345678", dr_reg); end
        exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
        exp_q.push_back(0); exp_q.push_back(1);
        exp_q.push_back(1); exp_q.push_back(0);
        exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
        for (int i = 0; i < 37; i++) exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(1); exp_q.push_back(0);
        ok = (tms_q.size() - mark == 51);
        if (ok) for (int i = 0; i < 51; i++) if (tms_q[mark+i] != exp_q[i]) ok = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL full_tms_trace: %0d rises or wrong path, want 51 on the TAP path", tms_q.size() - mark); end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_dr !== DR_INIT) begin
            errors++; $display("FAIL full_pulse_hold: vld=%b rsp_dr=%h want 0 %h", rsp_valid, rsp_dr, DR_INIT);
        end
    endtask

    task automatic test_ir_only;
        int lat, dc;
        dc = dr_caps;
        run_cmd(2'b01, 38'h3F_0000_FFFF, 1'b1, lat);
        checks++;
        if (lat != 64) begin errors++; $display("FAIL iro_latency: %0d want 64", lat); end
        checks++;
        if (rsp_ir !== 2'b10) begin errors++; $display("FAIL iro_rsp_ir: %b want 10", rsp_ir); end
        checks++;
        if (rsp_dr !== 38'h0) begin errors++; $display("FAIL iro_rsp_dr: %h want 0", rsp_dr); end
        checks++;
        if (dr_caps != dc) begin errors++; $display("FAIL iro_no_dr_scan: %0d DR scans, want 0", dr_caps - dc); end
        checks++;
        if (ir_reg !== 2'b01 || dr_reg !== 38'h15_1234_5678) begin
            errors++; $display("FAIL iro_target: ir=%b dr=%h want 01 1512345678", ir_reg, dr_reg);
        end
    endtask

    task automatic test_back_to_back;
        int ic, lat_a, lat_b;
        bit quiet;
        ic = ir_caps;
        @(negedge clk);
        cmd_ir = 2'b11; cmd_dr = 38'h0; cmd_ir_only = 1'b1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_ir = 2'b00; cmd_dr = 38'h00_0F0F_F0F0; cmd_ir_only = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept_a: rdy=%b busy=%b want 0 1", cmd_ready, busy);
        end
        lat_a = -1;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) begin lat_a = n; break; end
        end
        checks++;
        if (lat_a != 64) begin errors++; $display("FAIL b2b_latency_a: %0d want 64", lat_a); end
        checks++;
        if (rsp_ir !== 2'b01 || rsp_dr !== 38'h0) begin
            errors++; $display("FAIL b2b_rsp_a: ir=%b dr=%h want 01 0", rsp_ir, rsp_dr);
        end
        checks++;
        if (ir_reg !== 2'b11) begin errors++; $display("FAIL b2b_no_relatch: target ir=%b want 11", ir_reg); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_gap: rdy=%b busy=%b one cycle after rsp, want 0 1", cmd_ready, busy);
        end
        lat_b = -1;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) begin lat_b = n; break; end
        end
        checks++;
        if (lat_b != 408) begin errors++; $display("FAIL b2b_latency_b: %0d want 408", lat_b); end
        checks++;
        if (rsp_ir !== 2'b11 || rsp_dr !== 38'h15_1234_5678) begin
            errors++; $display("FAIL b2b_rsp_b: ir=%b dr=%h want 11 1512345678", rsp_ir, rsp_dr);
        end
        checks++;
        if (dr_reg !== 38'h00_0F0F_F0F0 || ir_reg !== 2'b00) begin
            errors++; $display("FAIL b2b_target_b: ir=%b dr=%h want 00 000f0ff0f0", ir_reg, dr_reg);
        end
        quiet = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy !== 1'b0) quiet = 0;
        end
        checks++;
        if (!quiet || ir_caps - ic != 2) begin
            errors++; $display("FAIL b2b_count: %0d IR scans quiet=%0d, want 2 and idle", ir_caps - ic, quiet);
        end
    endtask

    task automatic test_reset_mid_shift;
        int rc, lat;
        bit hit;
        rc = rsp_cnt0;
        @(negedge clk);
        cmd_ir = 2'b10; cmd_dr = 38'h11_1111_1111; cmd_ir_only = 1'b0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        hit = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (dr_bits == 20 && st == SHDR) begin hit = 1; break; end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL mid_reach_bit20: dr_bits=%0d want 20", dr_bits); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({tck, tms, tdi, cmd_ready, rsp_valid, busy} !== 6'b010001 || rsp_ir !== 2'b00 || rsp_dr !== 38'h0) begin
            errors++; $display("FAIL mid_reset_vals: ctrl=%b ir=%b dr=%h want 010001 0 0",
                               {tck, tms, tdi, cmd_ready, rsp_valid, busy}, rsp_ir, rsp_dr);
        end
        check_init("mid");
        checks++;
        if (rsp_cnt0 != rc) begin errors++; $display("FAIL mid_no_rsp: %0d rsp_valid pulses, want 0", rsp_cnt0 - rc); end
        run_cmd(2'b01, 38'h3F_FFFF_0001, 1'b0, lat);
        checks++;
        if (lat != 408 || rsp_ir !== 2'b01 || rsp_dr !== DR_INIT) begin
            errors++; $display("FAIL mid_next_cmd: lat=%0d ir=%b dr=%h want 408 01 %h", lat, rsp_ir, rsp_dr, DR_INIT);
        end
        checks++;
        if (dr_reg !== 38'h3F_FFFF_0001) begin errors++; $display("FAIL mid_next_target: %h want 3fffff0001", dr_reg); end
    endtask

    task automatic test_tck_div1;
        int lat;
        @(negedge clk);
        sel = 1'b1;
        checks++;
        if (cmd_ready1 !== 1'b1 || tck1 !== 1'b0) begin
            errors++; $display("FAIL div1_ready: rdy=%b tck=%b want 1 0", cmd_ready1, tck1);
        end
        @(negedge clk);
        cmd_ir = 2'b10; cmd_dr = 38'h2A_AAAA_5555; cmd_ir_only = 1'b0; cmd_valid1 = 1'b1;
        @(posedge clk); #1;
        cmd_valid1 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk); #1;
            if (rsp_valid1 === 1'b1) begin lat = n; break; end
        end
        checks++;
        if (lat != 102) begin errors++; $display("FAIL div1_latency: %0d want 102", lat); end
        checks++;
        if (rsp_ir1 !== 2'b01 || rsp_dr1 !== 38'h3F_FFFF_0001) begin
            errors++; $display("FAIL div1_rsp: ir=%b dr=%h want 01 3fffff0001", rsp_ir1, rsp_dr1);
        end
        checks++;
        if (dr_reg !== 38'h2A_AAAA_5555 || ir_reg !== 2'b10) begin
            errors++; $display("FAIL div1_target: ir=%b dr=%h want 10 2aaaaa5555", ir_reg, dr_reg);
        end
    endtask

    initial begin
        test_reset;
        test_full_cmd;
        test_ir_only;
        test_back_to_back;
        test_reset_mid_shift;
        test_tck_div1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
